// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access opcodes, FSM states,
// wait-counter width and the latched request record.
package dmem_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        RD_NONE = 3'b000,
        RD_LB   = 3'b001,
        RD_LH   = 3'b010,
        RD_LW   = 3'b011,
        RD_LBU  = 3'b100,
        RD_LHU  = 3'b101
    } rd_op_e;

    typedef enum logic [1:0] {
        WR_NONE = 2'b00,
        WR_SB   = 2'b01,
        WR_SH   = 2'b10,
        WR_SW   = 2'b11
    } wr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  rd;
        logic [1:0]  wr;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/dmem_sram_array.sv
// Single-port synchronous word array with per-byte write enables.
// Read data is registered and holds its value until the next enabled access.
module dmem_sram_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: valid/ready request and response
// channels, fixed access latency, lane alignment, extension and error checks.
//
// state | meaning
// IDLE  | ready for a request (req_ready=1)
// WAIT  | request latched, counting down the extra access latency
// RESP  | response held on rsp_* until rsp_ready
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_read,
    input  logic [1:0]  req_write,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : {CNT_W{1'b0}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    req_t             lat_q, lat_d;
    req_t             in_req, cur;
    logic             go_resp, cur_err;
    logic [3:0]       be;
    logic [31:0]      wdata_lane, sram_rdata, load_data;
    logic [7:0]       lane_b;
    logic [15:0]      lane_h;

    function automatic logic req_err(input req_t r);
        logic bad;
        bad = 1'b0;
        if (r.rd != RD_NONE && r.wr != WR_NONE) bad = 1'b1;
        if (r.rd == 3'b110 || r.rd == 3'b111) bad = 1'b1;
        if (r.rd == RD_NONE && r.wr == WR_NONE) bad = 1'b1;
        if ((r.rd == RD_LH || r.rd == RD_LHU || r.wr == WR_SH) && r.addr[0]) bad = 1'b1;
        if ((r.rd == RD_LW || r.wr == WR_SW) && r.addr[1:0] != 2'b00) bad = 1'b1;
        if ({2'b00, r.addr[31:2]} >= 32'(DEPTH_WORDS)) bad = 1'b1;
        return bad;
    endfunction

    assign in_req    = '{addr: req_addr, rd: req_read, wr: req_write, wdata: req_wdata};
    assign req_ready = rst_n && (state_q == ST_IDLE);

    // With zero wait cycles the array is accessed on the handshake edge itself,
    // so the live request inputs drive it; otherwise the latched copy does.
    assign cur     = (state_q == ST_IDLE) ? in_req : lat_q;
    assign cur_err = req_err(cur);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        go_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    lat_d = in_req;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        be = 4'b0000;
        case (cur.wr)
            WR_SB:   be = 4'b0001 << cur.addr[1:0];
            WR_SH:   be = 4'b0011 << cur.addr[1:0];
            WR_SW:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        if (!go_resp || cur_err) be = 4'b0000;
    end

    assign wdata_lane = cur.wdata << {cur.addr[1:0], 3'b000};

    dmem_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .en_i    (go_resp && !cur_err),
        .be_i    (be),
        .addr_i  (cur.addr[AW+1:2]),
        .wdata_i (wdata_lane),
        .rdata_o (sram_rdata)
    );

    assign lane_b = 8'(sram_rdata >> {lat_q.addr[1:0], 3'b000});
    assign lane_h = 16'(sram_rdata >> {lat_q.addr[1], 4'b0000});

    always_comb begin
        load_data = '0;
        case (lat_q.rd)
            RD_LB:   load_data = {{24{lane_b[7]}}, lane_b};
            RD_LBU:  load_data = {24'h0, lane_b};
            RD_LH:   load_data = {{16{lane_h[15]}}, lane_h};
            RD_LHU:  load_data = {16'h0, lane_h};
            RD_LW:   load_data = sram_rdata;
            default: load_data = '0;
        endcase
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_err   = rsp_valid && cur_err;
    assign rsp_rdata = (rsp_valid && !cur_err) ? load_data : 32'h0;

endmodule
